// File: rtl/mantissa_arbiter.sv
// mantissa_arbiter: round-robin sharing of one pipelined mantissa add/sub datapath with a credit-protected result FIFO.
// Define MANT_ARB_PERF_EN to add saturating o_perf_issue_cnt / o_perf_stall_cnt counters.
module mantissa_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int SIZE_DATA  = 28,
   parameter int SIZE_SHIFT = 8,
   parameter int NUM_OP     = 1,
   parameter int DP_LATENCY = 2,
   parameter int FIFO_DEPTH = 4,
   localparam int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [NUM_REQ-1:0]               i_req_valid,
   output logic [NUM_REQ-1:0]               o_req_ready,
   input  logic [NUM_REQ-1:0]               i_req_sign_A,
   input  logic [NUM_REQ-1:0]               i_req_sign_B,
   input  logic [NUM_REQ*SIZE_DATA-1:0]     i_req_mantissa_A,
   input  logic [NUM_REQ*SIZE_DATA-1:0]     i_req_mantissa_B,
   input  logic [NUM_REQ*NUM_OP-1:0]        i_req_alu_op,
   input  logic [NUM_REQ-1:0]               i_req_diff_signal,
   input  logic [NUM_REQ*SIZE_SHIFT-1:0]    i_req_diff_value,
   output logic                             o_dp_sign_A,
   output logic [SIZE_DATA-1:0]             o_dp_mantissa_A,
   output logic                             o_dp_sign_B,
   output logic [SIZE_DATA-1:0]             o_dp_mantissa_B,
   output logic [NUM_OP-1:0]                o_dp_alu_op,
   output logic                             o_dp_diff_signal,
   output logic [SIZE_SHIFT-1:0]            o_dp_diff_value,
   input  logic                             i_dp_sign_result,
   input  logic [SIZE_DATA-1:0]             i_dp_mantissa,
   input  logic                             i_dp_overflow,
   output logic                             o_rsp_valid,
   input  logic                             i_rsp_ready,
   output logic [ID_W-1:0]                  o_rsp_id,
   output logic                             o_rsp_sign,
   output logic [SIZE_DATA-1:0]             o_rsp_mantissa,
   output logic                             o_rsp_overflow,
`ifdef MANT_ARB_PERF_EN
   output logic                             o_busy,
   output logic [31:0]                      o_perf_issue_cnt,
   output logic [31:0]                      o_perf_stall_cnt
`else
   output logic                             o_busy
`endif
);

   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH + DP_LATENCY + 1);
   localparam int ENTRY_W = ID_W + SIZE_DATA + 2;

   logic [ID_W-1:0]       r_rr_ptr;
   logic [DP_LATENCY-1:0] r_tag_vld;
   logic [ID_W-1:0]       r_tag_id [DP_LATENCY];
   logic [ENTRY_W-1:0]    r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_fifo_cnt;
   logic [CNT_W-1:0]      w_inflight;
   logic                  w_issue_ok;
   logic                  w_issue;
   logic [ID_W-1:0]       w_gnt_id;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_empty;
   logic                  w_full;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < DP_LATENCY; i++)
         w_inflight = w_inflight + CNT_W'(r_tag_vld[i]);
   end

   // Credits cover every op issued but not yet popped, so the FIFO can never overflow.
   assign w_issue_ok = (w_inflight + r_fifo_cnt) < CNT_W'(FIFO_DEPTH);

   // Walk downward so the requester closest after the pointer is the one left standing.
   always_comb begin
      w_issue  = 1'b0;
      w_gnt_id = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (w_issue_ok && i_req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
            w_issue  = 1'b1;
            w_gnt_id = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   assign o_req_ready      = w_issue ? (NUM_REQ'(1) << w_gnt_id) : '0;
   assign o_dp_sign_A      = w_issue & i_req_sign_A[w_gnt_id];
   assign o_dp_sign_B      = w_issue & i_req_sign_B[w_gnt_id];
   assign o_dp_diff_signal = w_issue & i_req_diff_signal[w_gnt_id];
   assign o_dp_mantissa_A  = w_issue ? i_req_mantissa_A[w_gnt_id*SIZE_DATA +: SIZE_DATA] : '0;
   assign o_dp_mantissa_B  = w_issue ? i_req_mantissa_B[w_gnt_id*SIZE_DATA +: SIZE_DATA] : '0;
   assign o_dp_alu_op      = w_issue ? i_req_alu_op[w_gnt_id*NUM_OP +: NUM_OP] : '0;
   assign o_dp_diff_value  = w_issue ? i_req_diff_value[w_gnt_id*SIZE_SHIFT +: SIZE_SHIFT] : '0;

   assign w_empty = (r_fifo_cnt == '0);
   assign w_full  = (r_fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign w_push  = r_tag_vld[DP_LATENCY-1];
   assign w_pop   = !w_empty & i_rsp_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_ptr   <= ID_W'(NUM_REQ - 1);
         r_tag_vld  <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_issue)
            r_rr_ptr <= w_gnt_id;
         r_tag_vld[0] <= w_issue;
         for (int i = 1; i < DP_LATENCY; i++)
            r_tag_vld[i] <= r_tag_vld[i-1];
         if (w_push)
            r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      r_tag_id[0] <= w_gnt_id;
      for (int i = 1; i < DP_LATENCY; i++)
         r_tag_id[i] <= r_tag_id[i-1];
      if (w_push)
         r_fifo[r_wr_ptr] <= {r_tag_id[DP_LATENCY-1], i_dp_sign_result, i_dp_overflow, i_dp_mantissa};
   end

   assign o_rsp_valid = !w_empty;
   assign {o_rsp_id, o_rsp_sign, o_rsp_overflow, o_rsp_mantissa} = w_empty ? '0 : r_fifo[r_rd_ptr];
   assign o_busy = (w_inflight != '0) | !w_empty;

   assert property (@(posedge i_clk) disable iff (!i_rst_n) !(w_push && w_full));

`ifdef MANT_ARB_PERF_EN
   logic [31:0] r_perf_issue;
   logic [31:0] r_perf_stall;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_perf_issue <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_issue && !(&r_perf_issue))
            r_perf_issue <= r_perf_issue + 32'd1;
         if (|i_req_valid && !w_issue_ok && !(&r_perf_stall))
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign o_perf_issue_cnt = r_perf_issue;
   assign o_perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_mantissa_arbiter.sv
// tb_mantissa_arbiter: randomized requesters and a fixed-latency stand-in datapath,
// checked against a queue-based model of issued-but-unpopped operations.
module tb_mantissa_arbiter;
   localparam int N  = 4;
   localparam int D  = 28;
   localparam int S  = 8;
   localparam int F  = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   req_valid, req_ready, sign_a, sign_b, alu_op, diff_sig;
   logic [N*D-1:0] mant_a, mant_b;
   logic [N*S-1:0] diff_val;
   logic           dp_sa, dp_sb, dp_ds, dp_sr, dp_ov;
   logic [0:0]     dp_op;
   logic [D-1:0]   dp_ma, dp_mb, dp_m;
   logic [S-1:0]   dp_dv;
   logic           rsp_valid, rsp_ready, rsp_sign, rsp_ovf, busy;
   logic [IW-1:0]  rsp_id;
   logic [D-1:0]   rsp_mant;
`ifdef MANT_ARB_PERF_EN
   logic [31:0]    perf_issue, perf_stall;
`endif

   mantissa_arbiter dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_sign_A(sign_a), .i_req_sign_B(sign_b),
      .i_req_mantissa_A(mant_a), .i_req_mantissa_B(mant_b),
      .i_req_alu_op(alu_op), .i_req_diff_signal(diff_sig), .i_req_diff_value(diff_val),
      .o_dp_sign_A(dp_sa), .o_dp_mantissa_A(dp_ma), .o_dp_sign_B(dp_sb), .o_dp_mantissa_B(dp_mb),
      .o_dp_alu_op(dp_op), .o_dp_diff_signal(dp_ds), .o_dp_diff_value(dp_dv),
      .i_dp_sign_result(dp_sr), .i_dp_mantissa(dp_m), .i_dp_overflow(dp_ov),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
      .o_rsp_sign(rsp_sign), .o_rsp_mantissa(rsp_mant), .o_rsp_overflow(rsp_ovf),
`ifdef MANT_ARB_PERF_EN
      .o_perf_issue_cnt(perf_issue), .o_perf_stall_cnt(perf_stall),
`endif
      .o_busy(busy)
   );

   function automatic logic [D+1:0] dp_fn(input logic sa, input logic sb, input logic op, input logic ds,
                                          input logic [D-1:0] ma, input logic [D-1:0] mb, input logic [S-1:0] dv);
      logic [D:0] sum;
      sum = op ? ({1'b0, ma} - {1'b0, mb >> dv}) : ({1'b0, ma} + {1'b0, mb >> dv});
      return {(ds ? (sb ^ op) : sa), sum[D], sum[D-1:0]};
   endfunction

   // Stand-in two-stage datapath: input register, then result register.
   logic           p_sa, p_sb, p_op, p_ds;
   logic [D-1:0]   p_ma, p_mb;
   logic [S-1:0]   p_dv;
   logic [D+1:0]   p_res;
   always @(posedge clk) begin
      p_sa <= dp_sa; p_sb <= dp_sb; p_op <= dp_op[0]; p_ds <= dp_ds;
      p_ma <= dp_ma; p_mb <= dp_mb; p_dv <= dp_dv;
      p_res <= dp_fn(p_sa, p_sb, p_op, p_ds, p_ma, p_mb, p_dv);
   end
   assign {dp_sr, dp_ov, dp_m} = p_res;

   typedef struct { int id; logic [D+1:0] res; int due; } exp_t;
   exp_t q[$];
   int ptr = N - 1;
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int m_issues = 0;
   int m_stalls = 0;
   int seen = 0;
   logic [N-1:0] pend = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      ptr = N - 1;
      pend = '0;
      m_issues = 0;
      m_stalls = 0;
   endtask

   // One cycle: compare outputs with the model, then advance the model across the edge.
   task automatic step();
      int g;
      logic [N-1:0] er;
      logic ev;
      #1;
      g = -1;
      if (q.size() < F)
         for (int k = 1; k <= N; k++)
            if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      ev = (q.size() > 0) && (q[0].due <= cyc);
      seen += $countones(req_ready & req_valid);
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("dp_mant_a", 64'(dp_ma), (g >= 0) ? 64'(mant_a[g*D +: D]) : 64'd0);
      chk("dp_diff_val", 64'(dp_dv), (g >= 0) ? 64'(diff_val[g*S +: S]) : 64'd0);
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      if (ev) begin
         chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
         chk("rsp_result", 64'({rsp_sign, rsp_ovf, rsp_mant}), 64'(q[0].res));
      end
      chk("busy", 64'(busy), 64'(q.size() > 0));
      if (|req_valid && q.size() >= F) m_stalls++;
      if (ev && rsp_ready) void'(q.pop_front());
      if (g >= 0) begin
         q.push_back('{g, dp_fn(sign_a[g], sign_b[g], alu_op[g], diff_sig[g],
                                mant_a[g*D +: D], mant_b[g*D +: D], diff_val[g*S +: S]), cyc + 3});
         ptr = g;
         m_issues++;
      end
      for (int i = 0; i < N; i++) pend[i] = req_valid[i] && (g != i);
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   // Pending requesters keep their fields; others draw fresh ones.
   task automatic gen(input logic [N-1:0] mask, input int vp, input int rp);
      for (int i = 0; i < N; i++) begin
         if (!(pend[i] && mask[i])) begin
            req_valid[i] = mask[i] && ($urandom_range(99) < vp);
            sign_a[i] = 1'($urandom);
            sign_b[i] = 1'($urandom);
            alu_op[i] = 1'($urandom);
            diff_sig[i] = 1'($urandom);
            mant_a[i*D +: D] = D'($urandom);
            mant_b[i*D +: D] = D'($urandom);
            diff_val[i*S +: S] = S'($urandom_range(5));
         end
      end
      rsp_ready = ($urandom_range(99) < rp);
      step();
   endtask

   initial begin
      int base;
      req_valid = '0; sign_a = '0; sign_b = '0; alu_op = '0; diff_sig = '0;
      mant_a = '0; mant_b = '0; diff_val = '0; rsp_ready = 1'b0;
      #2;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_rsp_id", 64'(rsp_id), 64'd0);
      chk("reset_rsp_mant", 64'(rsp_mant), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request from requester 2 with known operands.
      req_valid = 4'b0100;
      mant_a[2*D +: D] = 28'h0800000;
      mant_b[2*D +: D] = 28'h0400000;
      rsp_ready = 1'b1;
      #1 chk("single_grant", 64'(req_ready), 64'b0100);
      step();
      req_valid = '0;
      repeat (4) step();

      // All requesters streaming with a free consumer.
      repeat (20) gen(4'hF, 100, 100);
      repeat (6) gen(4'h0, 0, 100);

      // Blocked consumer: credits allow exactly FIFO_DEPTH issues.
      base = seen;
      repeat (8) gen(4'hF, 100, 0);
      chk("credit_issues", 64'(seen - base), 64'd4);
      repeat (10) gen(4'hF, 100, 100);
      repeat (6) gen(4'h0, 0, 100);

      // Park the pointer on 1, then 1 and 3 alternate.
      gen(4'b0010, 100, 100);
      repeat (8) gen(4'b1010, 100, 100);
      repeat (6) gen(4'h0, 0, 100);

      repeat (300) gen(4'hF, 50, 60);
      repeat (6) gen(4'h0, 0, 100);

      // Build two in flight plus one buffered, then reset mid-cycle.
      repeat (3) gen(4'b0001, 100, 0);
      req_valid = '0;
      rsp_ready = 1'b0;
      #1 chk("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid_reset_busy", 64'(busy), 64'd0);
      model_reset();
      @(negedge clk);
      cyc++;
      rst_n = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      #1 chk("post_reset_grant", 64'(req_ready), 64'b0001);
      step();
      repeat (10) gen(4'hF, 100, 100);
      repeat (6) gen(4'h0, 0, 100);
      repeat (8) gen(4'hF, 100, 0);
      repeat (6) gen(4'hF, 100, 100);
      repeat (6) gen(4'h0, 0, 100);
`ifdef MANT_ARB_PERF_EN
      chk("perf_issue", 64'(perf_issue), 64'(m_issues));
      chk("perf_stall", 64'(perf_stall), 64'(m_stalls));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
